// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts words over AXI-Stream and shifts them out as
// start / data (LSB first) / optional parity / stop bits at a runtime-programmable rate.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      txd,
  output logic                      busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [3:0] LastData = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

  state_e                    r_state, w_state_d;
  logic [DATA_WIDTH-1:0]     r_shift, w_shift_d;
  logic [PRESCALE_WIDTH-1:0] r_period, w_period_d;
  logic [PRESCALE_WIDTH-1:0] r_cnt, w_cnt_d;
  logic [3:0]                r_bit, w_bit_d;
  logic                      r_parity, w_parity_d;
  logic                      r_txd, w_txd_d;
  logic                      r_tready, w_tready_d;
  logic                      r_busy, w_busy_d;
  logic                      w_advance;
  logic                      w_par_calc;

  assign w_advance  = (r_cnt == '0);
  assign w_par_calc = (PARITY == 1) ? ~^s_axis_tdata : ^s_axis_tdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_tready <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_period <= w_period_d;
      r_cnt    <= w_cnt_d;
      r_bit    <= w_bit_d;
      r_parity <= w_parity_d;
      r_txd    <= w_txd_d;
      r_tready <= w_tready_d;
      r_busy   <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_period_d = r_period;
    w_cnt_d    = r_cnt;
    w_bit_d    = r_bit;
    w_parity_d = r_parity;
    w_txd_d    = r_txd;
    w_tready_d = r_tready;
    w_busy_d   = r_busy;

    // Bit-period down-counter; reloads from the prescale latched at handshake.
    if (r_state != StIdle) begin
      w_cnt_d = w_advance ? r_period : r_cnt - 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        w_txd_d    = 1'b1;
        w_tready_d = 1'b1;
        w_busy_d   = 1'b0;
        if (s_axis_tvalid && r_tready) begin
          w_state_d  = StStart;
          w_shift_d  = s_axis_tdata;
          w_period_d = prescale;
          w_cnt_d    = prescale;
          w_parity_d = w_par_calc;
          w_bit_d    = '0;
          w_txd_d    = 1'b0;
          w_tready_d = 1'b0;
          w_busy_d   = 1'b1;
        end
      end
      StStart: begin
        if (w_advance) begin
          w_state_d = StData;
          w_bit_d   = '0;
          w_txd_d   = r_shift[0];
        end
      end
      StData: begin
        if (w_advance) begin
          w_shift_d = r_shift >> 1;
          if (r_bit == LastData) begin
            w_bit_d = '0;
            if (PARITY != 0) begin
              w_state_d = StParity;
              w_txd_d   = r_parity;
            end else begin
              w_state_d = StStop;
              w_txd_d   = 1'b1;
            end
          end else begin
            w_bit_d = r_bit + 1'b1;
            w_txd_d = r_shift[1];
          end
        end
      end
      StParity: begin
        if (w_advance) begin
          w_state_d = StStop;
          w_bit_d   = '0;
          w_txd_d   = 1'b1;
        end
      end
      StStop: begin
        if (w_advance) begin
          if (r_bit == LastStop) begin
            w_state_d  = StIdle;
            w_bit_d    = '0;
            w_txd_d    = 1'b1;
            w_tready_d = 1'b1;
            w_busy_d   = 1'b0;
          end else begin
            w_bit_d = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign txd           = r_txd;
  assign s_axis_tready = r_tready;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parity/stop configurations checked every cycle
// against a frame-level queue model, plus directed frames with literal expectations.
module tb_uart_tx_serializer;

  localparam int N = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] prescale = 16'd3;
  logic [7:0]  tdata  [N];
  logic        tvalid [N];
  logic        tready [N];
  logic        txd    [N];
  logic        busy   [N];

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  uart_tx_serializer #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .PRESCALE_WIDTH(16)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .prescale(prescale), .s_axis_tdata(tdata[0]),
    .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]), .txd(txd[0]), .busy(busy[0])
  );
  uart_tx_serializer #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(2), .PRESCALE_WIDTH(16)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .prescale(prescale), .s_axis_tdata(tdata[1]),
    .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]), .txd(txd[1]), .busy(busy[1])
  );
  uart_tx_serializer #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .PRESCALE_WIDTH(16)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .prescale(prescale), .s_axis_tdata(tdata[2]),
    .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]), .txd(txd[2]), .busy(busy[2])
  );

  function automatic int par_mode(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
  endfunction

  function automatic int stop_n(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted word becomes a queue of expected txd values, one per cycle.
  logic mq [N][$];
  logic m_rdy [N];

  task automatic push_frame(input int k, input logic [7:0] d, input int p);
    logic bits [$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_mode(k) == 1) bits.push_back((ones % 2) == 0);
    if (par_mode(k) == 2) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < stop_n(k); i++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c <= p; c++) mq[k].push_back(bits[b]);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) m_rdy[k] = 1'b0;
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) begin
        for (int k = 0; k < N; k++) begin
          mq[k].delete();
          m_rdy[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (mq[k].size() != 0) begin
            void'(mq[k].pop_front());
            if (mq[k].size() == 0) m_rdy[k] = 1'b1;
          end else if (m_rdy[k] && tvalid[k]) begin
            push_frame(k, tdata[k], int'(prescale));
            m_rdy[k] = 1'b0;
          end else begin
            m_rdy[k] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of {txd, tready, busy} for all three instances.
  initial begin
    forever begin
      @(negedge aclk);
      for (int k = 0; k < N; k++) begin
        logic e_txd;
        e_txd = (mq[k].size() != 0) ? mq[k][0] : 1'b1;
        chk($sformatf("dut%0d txd/tready/busy", k), {29'd0, txd[k], tready[k], busy[k]},
            {29'd0, e_txd, m_rdy[k], mq[k].size() != 0});
      end
    end
  end

  // Sends one word on instance k from a negedge; records mid-bit txd samples and frame length.
  task automatic frame(input int k, input logic [7:0] d, input int p, input int chg,
                       input int newp, output int len, output int waited,
                       output logic [15:0] bits);
    len = 0;
    waited = 0;
    bits = '0;
    prescale = p[15:0];
    tvalid[k] = 1'b1;
    tdata[k] = d;
    while (!tready[k] && waited < 300) begin
      @(negedge aclk);
      waited++;
    end
    if (waited >= 300) chk($sformatf("dut%0d tready timeout", k), 32'd0, 32'd1);
    @(negedge aclk);
    tvalid[k] = 1'b0;
    while (busy[k] && len < 400) begin
      if ((len % (p + 1)) == (p / 2) && (len / (p + 1)) < 16) bits[len / (p + 1)] = txd[k];
      if (len == chg) prescale = newp[15:0];
      len++;
      @(negedge aclk);
    end
  endtask

  initial begin
    int          len, waited;
    logic [15:0] bits;
    logic [7:0]  b2b [3];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;
    for (int k = 0; k < N; k++) begin
      tvalid[k] = 1'b0;
      tdata[k]  = 8'h00;
    end

    // Reset hold and release.
    repeat (5) begin
      @(negedge aclk);
      chk("reset txd", {31'd0, txd[0]}, 32'd1);
      chk("reset busy/tready", {30'd0, busy[0], tready[0]}, 32'd0);
    end
    #2 aresetn = 1'b1;
    @(negedge aclk);
    chk("tready after release", {31'd0, tready[0]}, 32'd1);

    // Basic frame 0xA5, prescale 3.
    frame(0, 8'hA5, 3, -1, 0, len, waited, bits);
    chk("basic length", len, 32'd40);
    chk("basic bits", {22'd0, bits[9:0]}, {22'd0, 10'b1101001010});
    chk("basic tready back", {31'd0, tready[0]}, 32'd1);

    // Parity bits.
    frame(2, 8'hA5, 1, -1, 0, len, waited, bits);
    chk("even A5 length", len, 32'd22);
    chk("even A5 parity+stop", {30'd0, bits[10:9]}, 32'b10);
    frame(1, 8'hA5, 1, -1, 0, len, waited, bits);
    chk("odd A5 length", len, 32'd24);
    chk("odd A5 parity+stops", {29'd0, bits[11:9]}, 32'b111);
    frame(2, 8'h07, 1, -1, 0, len, waited, bits);
    chk("even 07 parity+stop", {30'd0, bits[10:9]}, 32'b11);

    // Back-to-back at prescale 0: one idle cycle between frames.
    for (int i = 0; i < 3; i++) begin
      frame(0, b2b[i], 0, -1, 0, len, waited, bits);
      chk($sformatf("b2b%0d length", i), len, 32'd10);
      chk($sformatf("b2b%0d data", i), {24'd0, bits[8:1]}, {24'd0, b2b[i]});
      if (i > 0) chk($sformatf("b2b%0d idle gap", i), waited, 32'd0);
    end

    // Prescale changed mid-frame only takes effect at the next handshake.
    frame(0, 8'h96, 3, 10, 7, len, waited, bits);
    chk("presc frame1 length", len, 32'd40);
    chk("presc frame1 data", {24'd0, bits[8:1]}, 32'h96);
    frame(0, 8'hC3, 7, -1, 0, len, waited, bits);
    chk("presc frame2 length", len, 32'd80);
    chk("presc frame2 data", {24'd0, bits[8:1]}, 32'hC3);

    // Reset during data bit 3 of 0xA5 (txd low there).
    prescale = 16'd3;
    tvalid[0] = 1'b1;
    tdata[0] = 8'hA5;
    @(negedge aclk);
    @(negedge aclk);
    tvalid[0] = 1'b0;
    repeat (17) @(negedge aclk);
    chk("pre-reset data bit3", {31'd0, txd[0]}, 32'd0);
    #2 aresetn = 1'b0;
    #1;
    chk("async reset txd", {31'd0, txd[0]}, 32'd1);
    chk("async reset busy/tready", {30'd0, busy[0], tready[0]}, 32'd0);
    tvalid[0] = 1'b1;
    tdata[0] = 8'h11;
    repeat (3) @(negedge aclk);
    tvalid[0] = 1'b0;
    #2 aresetn = 1'b1;
    @(negedge aclk);
    frame(0, 8'h3C, 3, -1, 0, len, waited, bits);
    chk("post-reset length", len, 32'd40);
    chk("post-reset bits", {22'd0, bits[9:0]}, {22'd0, 10'b1001111000});

    // Randomised traffic on all instances, with prescale churn and one reset pulse.
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      for (int k = 0; k < N; k++) begin
        tvalid[k] = ($urandom % 3) != 0;
        tdata[k]  = 8'($urandom);
      end
      if ((i % 37) == 0) prescale = 16'($urandom_range(0, 3));
      if (i == 1500) #2 aresetn = 1'b0;
      if (i == 1503) #2 aresetn = 1'b1;
    end
    for (int k = 0; k < N; k++) tvalid[k] = 1'b0;
    repeat (200) @(negedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
